// File: rtl/bus_xfer_ctrl.sv
// Register-to-register move controller for a shared tri-state bus.
// Queues move requests and sequences each one as DRIVE, LATCH, GAP.
module bus_xfer_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_src,
  input  logic [1:0] req_dst,
  output logic       req_ready,
  input  logic [3:0] bus,
  output logic [3:0] output_enable,
  output logic [3:0] load,
  output logic       busy,
  output logic       done,
  output logic [3:0] xfer_data,
  output logic       err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StLatch,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [1:0]    src_mem_q [DEPTH];
  logic [1:0]    dst_mem_q [DEPTH];
  logic [1:0]    cur_src_q, cur_dst_q;
  logic [3:0]    xfer_data_q;
  logic          err_q;

  logic          empty, full;
  logic          accept, legal, push, pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign legal  = (req_src != req_dst);
  assign accept = req_valid && req_ready && !reset;
  assign push   = accept && legal;
  assign pop    = (state_q == StIdle) && !empty && !reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StDrive;
      StDrive: state_d = StLatch;
      StLatch: state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      xfer_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        cur_src_q <= src_mem_q[rd_ptr_q[AW-1:0]];
        cur_dst_q <= dst_mem_q[rd_ptr_q[AW-1:0]];
      end
      if (state_q == StLatch) xfer_data_q <= bus;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem_q[wr_ptr_q[AW-1:0]] <= req_src;
      dst_mem_q[wr_ptr_q[AW-1:0]] <= req_dst;
    end
  end

  always_comb begin
    output_enable = 4'b0000;
    load          = 4'b0000;
    done          = 1'b0;
    busy          = 1'b0;
    err           = 1'b0;
    req_ready     = 1'b1;
    if (!reset) begin
      req_ready = !full;
      busy      = (state_q != StIdle) || !empty;
      err       = err_q;
      unique case (state_q)
        StDrive: output_enable = 4'b0001 << cur_src_q;
        StLatch: begin
          output_enable = 4'b0001 << cur_src_q;
          load          = 4'b0001 << cur_dst_q;
        end
        StGap:   done = 1'b1;
        default: ;
      endcase
    end
  end

  assign xfer_data = reset ? 4'h0 : xfer_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: single move, illegal request, back-to-back,
// reset mid-transfer and pointer wrap, with a per-cycle protocol monitor.
module tb_bus_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_src, req_dst;
  logic       req_ready;
  logic [3:0] bus;
  logic [3:0] output_enable, load;
  logic       busy, done, err;
  logic [3:0] xfer_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Register contents each source would put on the bus.
  logic [3:0] bus_val [4] = '{4'h3, 4'h9, 4'hA, 4'h6};

  logic [1:0] exp_src [$];
  logic [1:0] exp_dst [$];
  logic [1:0] cur_src, cur_dst;
  int cyc, ndone, last_done;
  bit check_gap, mon_on;

  bus_xfer_ctrl #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .req_ready    (req_ready),
    .bus          (bus),
    .output_enable(output_enable),
    .load         (load),
    .busy         (busy),
    .done         (done),
    .xfer_data    (xfer_data),
    .err          (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus = 4'h0;
    for (int i = 0; i < 4; i++) if (output_enable[i]) bus = bus_val[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("oe_onehot", 32'($countones(output_enable) <= 1), 1);
      chk("load_onehot", 32'($countones(load) <= 1), 1);
      chk("oe_load_overlap", 32'(output_enable & load), 0);
    end
  end

  // Scoreboard step run right after each active edge.
  task automatic step();
    if (output_enable != 4'b0 && load == 4'b0) begin
      chk("drive_expected", 32'(exp_src.size() != 0), 1);
      if (exp_src.size() != 0) begin
        cur_src = exp_src.pop_front();
        cur_dst = exp_dst.pop_front();
        chk("drive_oe", 32'(output_enable), 32'(4'b0001 << cur_src));
      end
    end
    if (load != 4'b0) begin
      chk("latch_oe", 32'(output_enable), 32'(4'b0001 << cur_src));
      chk("latch_load", 32'(load), 32'(4'b0001 << cur_dst));
    end
    if (done) begin
      chk("done_data", 32'(xfer_data), 32'(bus_val[cur_src]));
      ndone++;
      if (check_gap && ndone > 1) chk("done_gap", 32'(cyc - last_done), 4);
      last_done = cyc;
    end
  endtask

  task automatic tick();
    if (req_valid && req_ready && !reset && req_src != req_dst) begin
      exp_src.push_back(req_src);
      exp_dst.push_back(req_dst);
    end
    @(posedge clk);
    #1;
    cyc++;
    step();
  endtask

  task automatic req(input logic [1:0] s, input logic [1:0] d);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
  endtask

  logic [1:0] w_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
  logic [1:0] w_dst [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    int idx;
    reset = 1'b1; req_valid = 1'b0; req_src = 2'd0; req_dst = 2'd0;
    cyc = 0; ndone = 0; last_done = 0; check_gap = 0; mon_on = 0;
    cur_src = 2'd0; cur_dst = 2'd0;
    tick(); tick();
    mon_on = 1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_oe", 32'(output_enable), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_xfer", 32'(xfer_data), 0);
    reset = 1'b0;

    // Single move 2 -> 0.
    req(2'd2, 2'd0);
    tick(); req_valid = 1'b0;
    chk("s_idle_busy", 32'(busy), 1);
    chk("s_idle_oe", 32'(output_enable), 0);
    tick();
    chk("s_drive_oe", 32'(output_enable), 32'h4);
    chk("s_drive_load", 32'(load), 0);
    tick();
    chk("s_latch_oe", 32'(output_enable), 32'h4);
    chk("s_latch_load", 32'(load), 32'h1);
    tick();
    chk("s_gap_done", 32'(done), 1);
    chk("s_gap_xfer", 32'(xfer_data), 32'hA);
    chk("s_gap_oe", 32'(output_enable), 0);
    chk("s_gap_load", 32'(load), 0);
    tick();
    chk("s_end_done", 32'(done), 0);
    chk("s_end_busy", 32'(busy), 0);
    chk("s_hold_xfer", 32'(xfer_data), 32'hA);

    // Illegal request 3 -> 3.
    req(2'd3, 2'd3);
    tick(); req_valid = 1'b0;
    chk("ill_err", 32'(err), 1);
    chk("ill_busy", 32'(busy), 0);
    chk("ill_oe", 32'(output_enable), 0);
    chk("ill_load", 32'(load), 0);
    tick();
    chk("ill_err_clr", 32'(err), 0);
    chk("ill_busy2", 32'(busy), 0);
    chk("ill_xfer", 32'(xfer_data), 32'hA);

    // Back-to-back: three requests in consecutive cycles.
    ndone = 0; check_gap = 1;
    req(2'd1, 2'd3); tick();
    req(2'd3, 2'd2); tick();
    chk("b2b_ready_one", 32'(req_ready), 1);
    req(2'd0, 2'd1); tick();
    req_valid = 1'b0;
    chk("b2b_full_ready", 32'(req_ready), 0);
    for (int i = 0; i < 40 && ndone < 3; i++) tick();
    chk("b2b_ndone", 32'(ndone), 3);
    tick();
    chk("b2b_busy", 32'(busy), 0);
    chk("b2b_xfer", 32'(xfer_data), 32'h3);
    chk("b2b_sb_empty", 32'(exp_src.size()), 0);
    check_gap = 0;

    // Reset while in LATCH.
    ndone = 0;
    req(2'd1, 2'd3); tick(); req_valid = 1'b0;
    tick();
    tick();
    chk("r_latch_load", 32'(load), 32'h8);
    reset = 1'b1;
    req(2'd0, 2'd2);
    tick();
    chk("r_oe", 32'(output_enable), 0);
    chk("r_load", 32'(load), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_done", 32'(done), 0);
    chk("r_xfer", 32'(xfer_data), 0);
    chk("r_ready", 32'(req_ready), 1);
    reset = 1'b0; req_valid = 1'b0;
    tick(); tick();
    chk("r_after_busy", 32'(busy), 0);
    chk("r_after_ndone", 32'(ndone), 0);
    chk("r_after_xfer", 32'(xfer_data), 0);

    // Wrap: 2*DEPTH+1 moves, issued whenever the queue has room.
    ndone = 0; idx = 0;
    for (int i = 0; i < 200 && ndone < 5; i++) begin
      bit taken;
      if (idx < 5) req(w_src[idx], w_dst[idx]);
      else req_valid = 1'b0;
      taken = req_valid && req_ready;
      tick();
      if (taken) idx++;
    end
    req_valid = 1'b0;
    chk("wrap_issued", 32'(idx), 5);
    chk("wrap_ndone", 32'(ndone), 5);
    chk("wrap_sb_empty", 32'(exp_src.size()), 0);
    tick();
    chk("wrap_busy", 32'(busy), 0);
    chk("wrap_xfer", 32'(xfer_data), 32'hA);

    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning request-queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  move request present.
REQ-005 SHALL have port req_src  input  2  index of the source register that drives the bus.
REQ-006 SHALL have port req_dst  input  2  index of the destination register that loads from the bus.
REQ-007 SHALL have port req_ready  output  1  queue can accept a request.
REQ-008 SHALL have port bus  input  4  shared tri-state data bus, observed only.
REQ-009 SHALL have port output_enable  output  4  one-hot source drive enables, one per register.
REQ-010 SHALL have port load  output  4  one-hot destination load strobes, one per register.
REQ-011 SHALL have port busy  output  1  a transfer is in progress or the queue is non-empty.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a transfer completes.
REQ-013 SHALL have port xfer_data  output  4  bus value captured by the last completed transfer.
REQ-014 SHALL have port err  output  1  one-cycle pulse when an illegal request is rejected.

Function
REQ-015 A request SHALL be accepted on a rising clk edge where req_valid=1 and req_ready=1.
REQ-016 req_ready SHALL equal 1 exactly when the queue holds fewer than DEPTH entries, independent of req_valid.
REQ-017 A request with req_src==req_dst SHALL be accepted but not enqueued, and err SHALL be 1 for the following cycle only.
REQ-018 Legal requests SHALL be executed in FIFO order, one at a time.
REQ-019 The FSM SHALL have the states IDLE, DRIVE, LATCH and GAP; each non-IDLE state SHALL last exactly one cycle.
REQ-020 IDLE SHALL go to DRIVE, popping the queue head, when the queue is non-empty; otherwise it SHALL stay in IDLE.
REQ-021 DRIVE SHALL assert output_enable[src] only, with load=0, to allow the bus to settle.
REQ-022 LATCH SHALL assert output_enable[src] and load[dst]; the destination register captures on the edge ending LATCH.
REQ-023 On the edge ending LATCH, xfer_data SHALL register the bus value.
REQ-024 GAP SHALL drive output_enable=0 and load=0 as bus turnaround, SHALL assert done=1, and SHALL then go to IDLE.
REQ-025 Latency SHALL be fixed: with an empty queue and IDLE state, a request accepted at edge N gives DRIVE in cycle N+1, LATCH in N+2, and GAP/done in N+3; the earliest next DRIVE is N+5.
REQ-026 output_enable SHALL never have more than one bit set, and load SHALL never have more than one bit set.
REQ-027 load[i] and output_enable[i] SHALL never be asserted together for the same i.
REQ-028 An accept and a pop in the same cycle on a full queue SHALL be disallowed (req_ready=0); on a non-full queue both SHALL take effect.
REQ-029 Queue pointers SHALL wrap modulo DEPTH, with an extra bit to distinguish full from empty.
REQ-030 busy SHALL equal (state!=IDLE) OR (queue non-empty).
REQ-031 xfer_data SHALL hold its value between transfers.

Reset
REQ-032 While reset=1 at a rising edge, the controller SHALL enter IDLE and empty the queue.
REQ-033 During reset, output_enable, load, done, err and busy SHALL be driven to 0, req_ready to 1, and xfer_data to 4'h0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer: enables and strobes SHALL be 0 from the next cycle, with no done pulse and no xfer_data update.
REQ-035 Requests presented while reset=1 SHALL be ignored.

Verification
REQ-036 Single move: src=2, dst=0, bus=4'hA in LATCH -> output_enable=0100 in N+1; output_enable=0100 with load=0001 in N+2; done=1 and xfer_data=4'hA in N+3.
REQ-037 Illegal request: src=dst=3 -> err=1 for one cycle; no output_enable or load activity; queue unchanged.
REQ-038 Back-to-back: three requests in consecutive cycles with DEPTH=2 -> req_ready=0 while the queue is full; all three execute in order, with done pulses 4 cycles apart.
REQ-039 Reset in LATCH: assert reset -> output_enable=0 and load=0 next cycle, busy=0, no done pulse, and xfer_data=4'h0.
REQ-040 Wrap: 2*DEPTH+1 legal moves -> each one executes in FIFO order with correct one-hot enables, confirming pointer wrap.
REQ-041 Protocol checks SHALL run on every cycle: at most one output_enable bit, at most one load bit, and no same-index overlap of output_enable and load.
